// File: rtl/clock_pkg.sv
// Shared time-field definitions for the clock core, splitter and set-entry front end.
package clock_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] HOUR_MAX   = 6'd23;
  localparam logic [TIME_W-1:0] MINSEC_MAX = 6'd59;

  localparam logic [1:0] FIELD_IDLE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // Edit state doubles as the field code shown on the display.
  typedef enum logic [1:0] {
    StIdle = FIELD_IDLE,
    StHour = FIELD_HOUR,
    StMin  = FIELD_MIN,
    StSec  = FIELD_SEC
  } field_e;

  // Modular +1 within 0..max; anything out of range folds back to 0.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  // Modular -1 within 0..max; anything out of range folds back to max.
  function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return ((v == '0) || (v > max)) ? max : v - 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton path: 2-FF synchronizer, stability counter and press-event pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk50,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic sync1_q, sync2_q;
  logic state_q, state_d;
  logic evt_q, evt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from the debounced state long enough.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    evt_d   = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CntMax) begin
        state_d = sync2_q;
        evt_d   = sync2_q;  // only the released->pressed flip is an event
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer (inverting to active-high) and debounce state.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign pressed   = state_q;
  assign press_evt = evt_q;

endmodule

// File: rtl/time_set_entry.sv
// Pushbutton time editor: walks hour/minute/second fields and strobes load on commit.
module time_set_entry
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              key_mode_n,
  input  logic              key_inc_n,
  input  logic              key_dec_n,
  input  logic              key_cancel_n,
  input  logic [TIME_W-1:0] hour_in,
  input  logic [TIME_W-1:0] min_in,
  input  logic [TIME_W-1:0] sec_in,
  output logic [TIME_W-1:0] hour_set,
  output logic [TIME_W-1:0] min_set,
  output logic [TIME_W-1:0] sec_set,
  output logic              load,
  output logic [1:0]        field
);

  logic mode_evt, inc_evt, dec_evt, cancel_evt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk50     (clk50),
    .reset     (reset),
    .key_n     (key_mode_n),
    .pressed   (),
    .press_evt (mode_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk50     (clk50),
    .reset     (reset),
    .key_n     (key_inc_n),
    .pressed   (),
    .press_evt (inc_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
    .clk50     (clk50),
    .reset     (reset),
    .key_n     (key_dec_n),
    .pressed   (),
    .press_evt (dec_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cancel (
    .clk50     (clk50),
    .reset     (reset),
    .key_n     (key_cancel_n),
    .pressed   (),
    .press_evt (cancel_evt)
  );

  field_e            state_q, state_d;
  logic [TIME_W-1:0] hour_q, hour_d;
  logic [TIME_W-1:0] min_q, min_d;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic              load_q, load_d;
  logic              step_up, step_dn;

  // Inc together with dec cancels out.
  assign step_up = inc_evt & ~dec_evt;
  assign step_dn = dec_evt & ~inc_evt;

  // Edit FSM: cancel beats mode, mode beats inc/dec (dropped, not deferred).
  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    load_d  = 1'b0;
    if (state_q == StIdle) begin
      if (mode_evt) begin
        hour_d  = hour_in;
        min_d   = min_in;
        sec_d   = sec_in;
        state_d = StHour;
      end
    end else if (cancel_evt) begin
      state_d = StIdle;
    end else if (mode_evt) begin
      case (state_q)
        StHour:  state_d = StMin;
        StMin:   state_d = StSec;
        default: begin
          state_d = StIdle;
          load_d  = 1'b1;
        end
      endcase
    end else if (step_up || step_dn) begin
      case (state_q)
        StHour:  hour_d = step_up ? wrap_inc(hour_q, HOUR_MAX) : wrap_dec(hour_q, HOUR_MAX);
        StMin:   min_d  = step_up ? wrap_inc(min_q, MINSEC_MAX) : wrap_dec(min_q, MINSEC_MAX);
        default: sec_d  = step_up ? wrap_inc(sec_q, MINSEC_MAX) : wrap_dec(sec_q, MINSEC_MAX);
      endcase
    end
  end

  // State, set registers and commit strobe.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      load_q  <= load_d;
    end
  end

  assign hour_set = hour_q;
  assign min_set  = min_q;
  assign sec_set  = sec_q;
  assign load     = load_q;
  assign field    = state_q;

endmodule

// File: tb/tb_time_set_entry.sv
// Randomized bench for time_set_entry against an event-level reference model.
module tb_time_set_entry;

  localparam int unsigned D = 4;

  localparam logic [3:0] K_MODE   = 4'b0001;
  localparam logic [3:0] K_INC    = 4'b0010;
  localparam logic [3:0] K_DEC    = 4'b0100;
  localparam logic [3:0] K_CANCEL = 4'b1000;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       key_mode_n = 1'b1, key_inc_n = 1'b1, key_dec_n = 1'b1, key_cancel_n = 1'b1;
  logic [5:0] hour_in = '0, min_in = '0, sec_in = '0;
  logic [5:0] hour_set, min_set, sec_set;
  logic       load;
  logic [1:0] field;

  time_set_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk50        (clk50),
    .reset        (reset),
    .key_mode_n   (key_mode_n),
    .key_inc_n    (key_inc_n),
    .key_dec_n    (key_dec_n),
    .key_cancel_n (key_cancel_n),
    .hour_in      (hour_in),
    .min_in       (min_in),
    .sec_in       (sec_in),
    .hour_set     (hour_set),
    .min_set      (min_set),
    .sec_set      (sec_set),
    .load         (load),
    .field        (field)
  );

  always #5 clk50 = ~clk50;

  int total = 0;
  int bad = 0;
  int load_seen = 0;

  // Reference model: edit position, field values and expected number of load cycles.
  int m_field = 0, m_h = 0, m_m = 0, m_s = 0, m_loads = 0;

  // Count every cycle load is high, so a stretched strobe shows up as an extra count.
  always @(negedge clk50) if (load) load_seen++;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".field"}, int'(field), m_field);
    check({tag, ".hour"}, int'(hour_set), m_h);
    check({tag, ".min"}, int'(min_set), m_m);
    check({tag, ".sec"}, int'(sec_set), m_s);
    check({tag, ".loads"}, load_seen, m_loads);
  endtask

  function automatic int wrap(input int v, input int modulus);
    return (v % modulus + modulus) % modulus;
  endfunction

  // Apply one debounced event set to the model.
  task automatic model_evt(input logic [3:0] mask);
    bit mode = mask[0], inc = mask[1], dec = mask[2], cancel = mask[3];
    int step = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
    if (m_field == 0) begin
      if (mode) begin
        m_h = hour_in; m_m = min_in; m_s = sec_in;
        m_field = 1;
      end
    end else if (cancel) begin
      m_field = 0;
    end else if (mode) begin
      if (m_field == 3) begin
        m_field = 0;
        m_loads++;
      end else begin
        m_field++;
      end
    end else if (step != 0) begin
      if (m_field == 1) m_h = wrap(m_h + step, 24);
      else if (m_field == 2) m_m = wrap(m_m + step, 60);
      else m_s = wrap(m_s + step, 60);
    end
  endtask

  task automatic set_keys(input logic [3:0] mask);
    key_mode_n   = ~mask[0];
    key_inc_n    = ~mask[1];
    key_dec_n    = ~mask[2];
    key_cancel_n = ~mask[3];
  endtask

  // Hold the keys for 'hold' cycles, release, and let the release settle.
  task automatic press(input logic [3:0] mask, input int hold, input string tag);
    model_evt(mask);
    @(posedge clk50); #1;
    set_keys(mask);
    repeat (hold) @(posedge clk50);
    #1;
    set_keys(4'b0000);
    repeat (D + 6) @(posedge clk50);
    #1;
    check_all(tag);
  endtask

  task automatic set_inputs(input int h, input int m, input int s);
    hour_in = 6'(h); min_in = 6'(m); sec_in = 6'(s);
  endtask

  initial begin
    logic [3:0] masks [7];
    masks[0] = K_MODE;  masks[1] = K_INC;  masks[2] = K_DEC;  masks[3] = K_CANCEL;
    masks[4] = K_MODE | K_INC;  masks[5] = K_INC | K_DEC;  masks[6] = K_CANCEL | K_MODE;

    repeat (3) @(posedge clk50);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk50);
    #1;
    check_all("reset");
    check("reset.load", int'(load), 0);

    set_inputs(5, 6, 7);
    press(K_INC, D + 4, "idle_inc");

    // Press latency: event in cycle D+2 after the sampling edge, field moves one edge later.
    set_inputs(13, 45, 7);
    model_evt(K_MODE);
    @(posedge clk50); #1;
    key_mode_n = 1'b0;
    repeat (D + 3) @(posedge clk50);
    #1 check("latency.before", int'(field), 0);
    @(posedge clk50);
    #1 check("latency.after", int'(field), 1);
    repeat (4) @(posedge clk50);
    #1 key_mode_n = 1'b1;
    repeat (D + 6) @(posedge clk50);
    #1 check_all("enter_13_45_7");

    // Wrap boundaries.
    press(K_CANCEL, D + 4, "cancel_hour");
    set_inputs(23, 0, 59);
    press(K_MODE, D + 4, "enter_23_0_59");
    press(K_INC, D + 4, "hour_23_inc");
    press(K_MODE, D + 4, "to_min");
    press(K_DEC, D + 4, "min_0_dec");
    press(K_MODE, D + 4, "to_sec");
    press(K_INC, D + 4, "sec_59_inc");
    press(K_CANCEL, D + 4, "cancel_sec");

    // Walk to 10/20/30 and commit.
    set_inputs(9, 22, 30);
    press(K_MODE, D + 4, "enter_9_22_30");
    press(K_INC, D + 4, "hour_inc");
    press(K_MODE, D + 4, "to_min2");
    press(K_DEC, D + 4, "min_dec1");
    press(K_DEC, D + 4, "min_dec2");
    press(K_MODE, D + 4, "to_sec2");
    set_inputs(1, 2, 3);
    press(K_MODE, D + 4, "commit");
    check("commit.hour", int'(hour_set), 10);
    check("commit.min", int'(min_set), 20);
    check("commit.sec", int'(sec_set), 30);

    // Short glitch never becomes an event.
    @(posedge clk50); #1 key_mode_n = 1'b0;
    repeat (3) @(posedge clk50);
    #1 key_mode_n = 1'b1;
    repeat (D + 6) @(posedge clk50);
    #1 check_all("glitch");

    // Long hold in MIN gives a single step.
    set_inputs(4, 30, 8);
    press(K_MODE, D + 4, "enter_hold");
    press(K_MODE, D + 4, "to_min_hold");
    press(K_INC, 100, "hold_inc");
    check("hold_inc.min", int'(min_set), 31);

    // Mode+inc in HOUR: move on, hour unchanged.
    press(K_CANCEL, D + 4, "cancel_min");
    press(K_MODE, D + 4, "enter_combo");
    press(K_MODE | K_INC, D + 4, "mode_inc_hour");
    check("mode_inc.hour", int'(hour_set), 4);

    // Reset mid-edit: immediate IDLE, everything cleared, no load.
    @(posedge clk50); #3 reset = 1'b1;
    #1;
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    check_all("reset_mid");
    check("reset_mid.load", int'(load), 0);
    repeat (2) @(posedge clk50);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk50);
    #1 check_all("after_reset");

    // Random walk over keys and running-time inputs.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] mask;
      int idx = $urandom_range(0, 9);
      if (idx > 6) idx = (idx == 7) ? 0 : idx - 7;
      mask = masks[idx];
      if (m_field == 0 && mask == (K_CANCEL | K_MODE)) mask = K_CANCEL;
      if (m_field == 0)
        set_inputs($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      press(mask, D + 4 + $urandom_range(0, 10), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_entry.md
# time_set_entry

Pushbutton front end that writes a new time into the settable clock core. Debounces four board keys and walks an edit FSM through hour, minute and second fields, starting from the currently running time. On commit it presents `hour_set`/`min_set`/`sec_set` with a one-cycle `load` strobe to the clock core's set port. Sits between the board keys and the clock core, in the 50 MHz domain ahead of the 1 Hz divider.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a key change (20 ms at 50 MHz); legal range ≥ 2.
- `clk50` in 1: single clock, 50 MHz; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `key_mode_n` in 1: raw button, active-low, asynchronous to `clk50`.
- `key_inc_n` in 1: raw button, active-low, asynchronous.
- `key_dec_n` in 1: raw button, active-low, asynchronous.
- `key_cancel_n` in 1: raw button, active-low, asynchronous.
- `hour_in` in 6: running hour from the clock core, 0..23.
- `min_in` in 6: running minute, 0..59.
- `sec_in` in 6: running second, 0..59.
- `hour_set` out 6: edited hour, 0..23.
- `min_set` out 6: edited minute, 0..59.
- `sec_set` out 6: edited second, 0..59.
- `load` out 1: one-cycle commit strobe.
- `field` out 2: edit state, 0 = IDLE, 1 = HOUR, 2 = MIN, 3 = SEC. Drives display blinking.

## Operation
- Each key path:
  - 2-FF synchronizer, inverted to active-high.
  - Debounce counter: counts while the synced value differs from the debounced state, and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced state flips.
  - A press event is a one-cycle pulse on the debounced 0→1 flip. Releases generate no event.
- FSM states and transitions:
  - IDLE: on mode, copy `hour_in`/`min_in`/`sec_in` into the set registers, then go to HOUR.
  - HOUR: on mode, go to MIN.
  - MIN: on mode, go to SEC.
  - SEC: on mode, go to IDLE and pulse `load`.
  - Any non-IDLE state: on cancel, go to IDLE with no `load`; set registers keep their values.
  - IDLE: inc, dec and cancel are ignored.
- Inc/dec act on the active field only, modular:
  - Hour: 23 + 1 → 0, and 0 − 1 → 23.
  - Minute and second: 59 + 1 → 0, and 0 − 1 → 59.
  - Arithmetic is 6-bit unsigned; results never leave the legal range.
- Simultaneous events in one cycle:
  - Cancel takes priority over mode, inc and dec.
  - Mode takes priority over inc and dec; the inc/dec is dropped, not deferred.
  - Inc together with dec is ignored.
- Holding a key produces exactly one event; there is no auto-repeat.
- Set registers hold their value in IDLE. `load` is asserted only on SEC→IDLE.

## Timing
- All outputs reset to 0: `hour_set`, `min_set`, `sec_set`, `load`, `field`. FSM resets to IDLE; debounced states reset to released; counters reset to 0.
- Press latency: a raw edge sampled at cycle 0 produces its event pulse in cycle `DEBOUNCE_CYCLES` + 2, provided the input stays stable.
- The FSM reacts to an event on the same edge that registers the event. State, field value and `load` update one cycle after the event pulse.
- `load` is high for exactly one cycle. `hour_set`/`min_set`/`sec_set` are stable from that cycle until the next IDLE→HOUR entry.
- The IDLE→HOUR copy samples `hour_in`/`min_in`/`sec_in` on the event cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event: the counter restarts whenever input and debounced state match.
- Reset asserted mid-edit returns to IDLE immediately and never emits `load`. The first event after reset release needs a full debounce period.

## Structure
- Shared package (`clock_pkg`):
  - Field encoding constants `FIELD_IDLE`/`HOUR`/`MIN`/`SEC`.
  - `HOUR_MAX` = 23, `MINSEC_MAX` = 59.
  - Time-field width 6, shared with the clock core and splitter.
- Sub-module `key_debounce`, parameter `DEBOUNCE_CYCLES`:
  - Ports: `clk50`, `reset`, `key_n` in; `pressed` (level), `press_evt` (pulse) out.
  - Instantiated four times.
- Top holds the FSM and the three set registers.

## Test plan
Benches run with `DEBOUNCE_CYCLES` = 4.
- Reset then idle: all outputs 0, `field` = 0. Raw inc press in IDLE gives no change.
- `hour_in`=13/`min_in`=45/`sec_in`=7, press mode: `field`=1 and set regs = 13/45/7, with the event 6 cycles after the raw edge.
- Enter HOUR at 23 and press inc → 0. In MIN at 0, press dec → 59. In SEC at 59, press inc → 0.
- Walk all fields to 10/20/30 and press mode from SEC: `load` high exactly 1 cycle, `field`=0, outputs 10/20/30.
- 3-cycle glitch on `key_mode_n`: no event. Hold inc for 100 cycles in MIN: exactly +1.
- Same-cycle mode+inc in HOUR: go to MIN with hour unchanged. Cancel in SEC: `field`=0, no `load`. Reset in MIN: immediate IDLE, no `load`.
